sar_adc_logic_param_xn: RTL

// - Parametrised multi-channel SAR conversion controller: NCH channels, NBIT resolution, shared frame timing.
// - Per channel: drives the capacitive-DAC weight word WP and resolves one bit per CLK from that channel's COMP.
// - Shared: sampling window SAMP_analog, data-ready strobe DR, programmable frame rate.
// - Sits between the analog SAR front-ends (COMP in, WP out) and the downstream sample packer (D, DR).

---
 rtl/sar_adc_logic_param_xn.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sar_adc_logic_param_xn.sv
// sar_adc_logic_param_xn: multi-channel SAR conversion controller.
// NCH channels convert in lockstep with shared frame timing; each channel
// drives its own DAC weight word and resolves one bit per clock from COMP.
// Optional build macro SAR_ADC_CH_MASK_EN adds CH_MASK: masked channels keep
// WP at 0 for the frame and report a zero code.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped; outputs at reset values, D held
// SAMPLE | sampling switch closed for SAMP_CYC cycles, WP cleared
// CONV   | one trial bit per cycle, MSB first (NBIT cycles)
// DONE   | DR pulse; result on D and still on WP
// WAIT   | frame-rate padding, WP cleared
module sar_adc_logic_param_xn #(
  parameter int NBIT     = 12,
  parameter int NCH      = 4,
  parameter int SAMP_CYC = 2,
  parameter int RATEW    = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                EN,
  input  logic [RATEW-1:0]    SAMP_RATE_MUX,
  input  logic [NCH-1:0]      COMP,
`ifdef SAR_ADC_CH_MASK_EN
  input  logic [NCH-1:0]      CH_MASK,
`endif
  output logic [NCH*NBIT-1:0] WP,
  output logic [NCH*NBIT-1:0] D,
  output logic                DR,
  output logic                SAMP_analog,
  output logic                BUSY
);

  localparam int BASE     = SAMP_CYC + NBIT + 1;
  localparam int MAX_RATE = (1 << RATEW) - 1;
  localparam int MAX_WAIT = BASE * ((1 << MAX_RATE) - 1);
  localparam int CNTW     = $clog2(MAX_WAIT + BASE + 1);
  localparam int BITW     = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [NBIT-1:0] MSB_ONE = {1'b1, {(NBIT-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE,
    S_WAIT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNTW-1:0]   cnt;
  logic              cnt_load;
  logic [CNTW-1:0]   cnt_load_val;
  logic              cnt_tc;
  logic              samp_entry;
  logic [RATEW-1:0]  rate_q;
  logic [NCH-1:0]    mask_q;
  logic [CNTW-1:0]   wait_len;
  logic [BITW-1:0]   bit_idx;
  logic [NBIT-1:0]   wp_q [NCH];
  logic [NBIT-1:0]   d_q  [NCH];

  assign cnt_tc     = (cnt == '0);
  assign samp_entry = (next_state == S_SAMPLE) && (state != S_SAMPLE);
  // In CONV the down-counter value is the trial bit position.
  assign bit_idx    = BITW'(cnt);
  assign wait_len   = CNTW'(BASE * ((1 << rate_q) - 1));

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= next_state;
  end

  // Shared phase timer: loaded on phase entry, terminal count at zero.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)              cnt <= '0;
    else if (cnt_load)      cnt <= cnt_load_val;
    else if (cnt != '0)     cnt <= cnt - CNTW'(1);
  end

  // Next-state and timer-load decode; EN is only honoured at frame boundaries.
  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      S_IDLE: begin
        if (EN) begin
          next_state   = S_SAMPLE;
          cnt_load     = 1'b1;
          cnt_load_val = CNTW'(SAMP_CYC - 1);
        end
      end
      S_SAMPLE: begin
        if (cnt_tc) begin
          next_state   = S_CONV;
          cnt_load     = 1'b1;
          cnt_load_val = CNTW'(NBIT - 1);
        end
      end
      S_CONV: begin
        if (cnt_tc) next_state = S_DONE;
      end
      S_DONE: begin
        if (wait_len != '0) begin
          next_state   = S_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = wait_len - CNTW'(1);
        end else if (EN) begin
          next_state   = S_SAMPLE;
          cnt_load     = 1'b1;
          cnt_load_val = CNTW'(SAMP_CYC - 1);
        end else begin
          next_state   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_tc) begin
          if (EN) begin
            next_state   = S_SAMPLE;
            cnt_load     = 1'b1;
            cnt_load_val = CNTW'(SAMP_CYC - 1);
          end else begin
            next_state   = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Frame configuration is latched at SAMPLE entry so mid-frame changes wait a frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)           rate_q <= '0;
    else if (samp_entry) rate_q <= SAMP_RATE_MUX;
  end

`ifdef SAR_ADC_CH_MASK_EN
  // Channel mask captured alongside the rate select.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)           mask_q <= '0;
    else if (samp_entry) mask_q <= CH_MASK;
  end
`else
  assign mask_q = '0;
`endif

  // Per-channel successive approximation and result capture.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int c = 0; c < NCH; c++) begin
        wp_q[c] <= '0;
        d_q[c]  <= '0;
      end
      DR <= 1'b0;
    end else begin
      DR <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        case (state)
          S_SAMPLE: wp_q[c] <= (cnt_tc && !mask_q[c]) ? MSB_ONE : '0;
          S_CONV: begin
            if (!mask_q[c]) begin
              wp_q[c][bit_idx] <= COMP[c];
              if (bit_idx != '0) wp_q[c][bit_idx - BITW'(1)] <= 1'b1;
            end
          end
          default: wp_q[c] <= '0;
        endcase
        if (state == S_CONV && cnt_tc)
          d_q[c] <= mask_q[c] ? '0 : {wp_q[c][NBIT-1:1], COMP[c]};
      end
      if (state == S_CONV && cnt_tc) DR <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_pack
    assign WP[c*NBIT +: NBIT] = wp_q[c];
    assign D[c*NBIT +: NBIT]  = d_q[c];
  end

  assign SAMP_analog = (state == S_SAMPLE);
  assign BUSY        = (state != S_IDLE);

endmodule
